// File: rtl/extend_pipe.sv
// -----------------------------------------------------------------------------
// extend_pipe: pipelined IN_W -> OUT_W immediate/operand extender.
//
// Per-transaction modes:
//   00 zero-extend, 01 sign-extend, 10 ones-fill, 11 high-placement.
// The extension is computed at accept time and stored in a 2-entry,
// strictly ordered output buffer. Both sides use valid/ready handshakes.
// Latency is one cycle. There is no combinational path from the input
// side to the output side.
//
// Optional feature (macro EXTEND_CNT_EN):
//   When defined, the design adds port xfer_cnt. It is a CNT_W-bit
//   wrapping count of completed output transfers.
// -----------------------------------------------------------------------------
module extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef EXTEND_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_SIGN = 2'b01;
  localparam logic [1:0] MODE_ONES = 2'b10;
  localparam logic [1:0] MODE_HIGH = 2'b11;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  // Extended value of the current input beat. It only matters on an accept.
  logic [OUT_W-1:0] ext_w;

  // Buffer storage. head_q is always the oldest entry and drives out_data
  // directly. It keeps its last value when the buffer drains, so out_data
  // holds steady while empty.
  logic [OUT_W-1:0] head_q, head_d;
  logic [OUT_W-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;

  logic push_w;
  logic pop_w;

  // ---------------------------------------------------------------------------
  // Extension logic
  // ---------------------------------------------------------------------------
  generate
    if (OUT_W == IN_W) begin : g_passthru
      // Every mode passes the value through when no widening is needed.
      logic [1:0] unused_mode_w;
      assign unused_mode_w = in_mode;
      assign ext_w         = in_data;
    end else begin : g_widen
      localparam int PAD_W = OUT_W - IN_W;

      // Select the fill pattern for the upper bits, or place the value high.
      always_comb begin
        ext_w = {{PAD_W{1'b0}}, in_data};
        case (in_mode)
          MODE_ZERO: ext_w = {{PAD_W{1'b0}}, in_data};
          MODE_SIGN: ext_w = {{PAD_W{in_data[IN_W-1]}}, in_data};
          MODE_ONES: ext_w = {{PAD_W{1'b1}}, in_data};
          MODE_HIGH: ext_w = {in_data, {PAD_W{1'b0}}};
          default:   ext_w = {{PAD_W{1'b0}}, in_data};
        endcase
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign out_valid = (count_q != CNT_EMPTY);
  assign out_data  = head_q;
  assign in_ready  = in_ready_q;

  // in_ready_q is registered from the next occupancy, so it already means
  // "count < 2". No extra full check is needed on the accept path.
  assign push_w = in_valid & in_ready_q;
  assign pop_w  = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Buffer next-state: shift-style 2-entry FIFO. The head is the oldest entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      CNT_EMPTY: begin
        if (push_w) begin
          head_d  = ext_w;
          count_d = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (push_w && pop_w) begin
          // The new beat becomes the head in the same cycle the old head leaves.
          head_d  = ext_w;
        end else if (push_w) begin
          tail_d  = ext_w;
          count_d = CNT_FULL;
        end else if (pop_w) begin
          count_d = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        if (pop_w) begin
          head_d = tail_q;
          if (push_w) begin
            // Unreachable while in_ready tracks occupancy. Kept so the
            // buffer still drops nothing if that ever changes.
            tail_d = ext_w;
          end else begin
            count_d = CNT_ONE;
          end
        end
      end
      default: begin
        count_d = CNT_EMPTY;
      end
    endcase
    in_ready_d = (count_d != CNT_FULL);
  end

  // Buffer and in_ready registers. Reset discards all buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNT_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef EXTEND_CNT_EN
  // ---------------------------------------------------------------------------
  // Output transfer counter. It wraps naturally at 2^CNT_W.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  assign xfer_cnt = xfer_cnt_q;

  // Advance once per completed output transfer.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (pop_w) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_extend_pipe: scoreboard bench for extend_pipe (IN_W=16, OUT_W=32).
//
// The driver pushes each hand-computed expected result when its beat is
// accepted. An independent monitor pops and compares on every output
// transfer. Directed checks cover reset, stall, and full behaviour.
// Define EXTEND_CNT_EN to also exercise xfer_cnt with CNT_W=4.
// -----------------------------------------------------------------------------
module tb_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef EXTEND_CNT_EN
  logic [3:0]  xfer_cnt;
`endif

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic lat_chk = 1'b0;

  extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef EXTEND_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: each output transfer is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got 0x%08h expected no output", out_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out_data !== e.data) begin
          errors++;
          $display("FAIL sb_data: got 0x%08h expected 0x%08h", out_data, e.data);
        end else begin
          $display("ok   sb_data: 0x%08h", out_data);
        end
        if (lat_chk) begin
          checks++;
          if (cyc - e.acc != 1) begin
            errors++;
            $display("FAIL sb_latency: got %0d cycles expected 1", cyc - e.acc);
          end
        end
      end
    end
  end

  // Present one beat and wait for it to be accepted (bounded wait).
  task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
    exp_t item;
    bit   acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        item.data = e;
        item.acc  = cyc;
        sb_q.push_back(item);
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of 0x%04h", d);
    end
  endtask

  // Wait (bounded) until every expected result has been observed.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Four modes on 0x8000, back to back, one-cycle latency
    lat_chk = 1'b1;
    send(16'h8000, 2'b00, 32'h0000_8000);
    send(16'h8000, 2'b01, 32'hFFFF_8000);
    send(16'h8000, 2'b10, 32'hFFFF_8000);
    send(16'h8000, 2'b11, 32'h8000_0000);
    // Mixed patterns
    send(16'h7FFF, 2'b01, 32'h0000_7FFF);
    send(16'h1234, 2'b10, 32'hFFFF_1234);
    send(16'h1234, 2'b11, 32'h1234_0000);
    send(16'h0000, 2'b01, 32'h0000_0000);
    send(16'hFFFF, 2'b00, 32'h0000_FFFF);
    drain();

    // Stall: fill the buffer, hold C, then release
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(16'h0001, 2'b00, 32'h0000_0001);
    send(16'h0002, 2'b00, 32'h0000_0002);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h0003;
    in_mode  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_data", out_data, 32'h0000_0001);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    send(16'h0003, 2'b00, 32'h0000_0003);
    drain();

    // Count=1 with push and pop on the same edge
    lat_chk = 1'b1;
    send(16'h0055, 2'b00, 32'h0000_0055);
    check("c1_out_data_first", out_data, 32'h0000_0055);
    send(16'h00AA, 2'b00, 32'h0000_00AA);
    check("c1_out_valid", {31'd0, out_valid}, 32'd1);
    check("c1_out_data", out_data, 32'h0000_00AA);
    check("c1_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // Asynchronous reset with two entries held
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(16'h0011, 2'b00, 32'h0000_0011);
    send(16'h0022, 2'b00, 32'h0000_0022);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_rel_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send(16'h0033, 2'b01, 32'h0000_0033);
    drain();

`ifdef EXTEND_CNT_EN
    // Counter wrap: 17 transfers with CNT_W=4 leave a count of 1
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("cnt_rst", {28'd0, xfer_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) begin
      send(16'(i), 2'b00, 32'(i));
    end
    drain();
    check("cnt_wrap", {28'd0, xfer_cnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("cnt_clear", {28'd0, xfer_cnt}, 32'd0);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
